// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the multi-field BCD stopwatch.
// Field spans and BCD conversion used at elaboration time.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    PAUSED,
    RUN,
    ADJUST,
    EXPIRED
  } sw_state_e;

  localparam int unsigned FIELD_MOD = 60;

  // Modulus of field idx: the top field wraps at top+1, the rest at 60.
  function automatic int unsigned field_mod(
    input int unsigned idx,
    input int unsigned nf,
    input int unsigned top
  );
    return (idx == nf - 1) ? top + 1 : FIELD_MOD;
  endfunction

  function automatic logic [7:0] to_bcd(input int unsigned v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

endpackage

// File: rtl/stopwatch_core_bcd_field.sv
// Two-digit BCD modulo-MOD counter with inc/dec/adjust/set.
// o_d is the value the register takes at the next edge.
module bcd_field
  import stopwatch_pkg::*;
#(
  parameter int unsigned MOD = FIELD_MOD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_inc,
  input  logic       i_dec,
  input  logic       i_adj,
  input  logic       i_set,
  input  logic [7:0] i_set_val,
  output logic [7:0] o_q,
  output logic [7:0] o_d,
  output logic       o_max,
  output logic       o_zero
);

  localparam logic [7:0] MAX_BCD = to_bcd(MOD - 1);

  logic [7:0] r_q;
  logic [7:0] w_inc_v;
  logic [7:0] w_dec_v;
  logic [7:0] w_d;

  assign o_max  = (r_q == MAX_BCD);
  assign o_zero = (r_q == 8'h00);

  always_comb begin
    w_inc_v = r_q;
    if (o_max)
      w_inc_v = 8'h00;
    else if (r_q[3:0] == 4'd9)
      w_inc_v = {r_q[7:4] + 4'd1, 4'd0};
    else
      w_inc_v = {r_q[7:4], r_q[3:0] + 4'd1};
  end

  always_comb begin
    w_dec_v = r_q;
    if (o_zero)
      w_dec_v = MAX_BCD;
    else if (r_q[3:0] == 4'd0)
      w_dec_v = {r_q[7:4] - 4'd1, 4'd9};
    else
      w_dec_v = {r_q[7:4], r_q[3:0] - 4'd1};
  end

  always_comb begin
    w_d = r_q;
    if (i_set)
      w_d = i_set_val;
    else if (i_inc || i_adj)
      w_d = w_inc_v;
    else if (i_dec)
      w_d = w_dec_v;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_q <= 8'h00;
    else
      r_q <= w_d;
  end

  assign o_q = r_q;
  assign o_d = w_d;

endmodule

// File: rtl/stopwatch_core.sv
// Multi-field BCD stopwatch/timer with adjust, lap hold and
// preset reload; fields chain carry/borrow from seconds upward.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int unsigned NUM_FIELDS = 2,
  parameter int unsigned TOP_LIMIT  = 59,
  parameter int unsigned SEL_W      =
    (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick_en,
  input  logic                    adj_tick,
  input  logic                    pause_pulse,
  input  logic                    clr_pulse,
  input  logic                    lap_pulse,
  input  logic                    adj,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    mode_down,
  output logic [8*NUM_FIELDS-1:0] count_bcd,
  output logic [8*NUM_FIELDS-1:0] disp_bcd,
  output logic                    running,
  output logic                    expired,
  output logic                    lap_active,
  output logic                    rollover
);

  localparam int unsigned CW = 8 * NUM_FIELDS;

  sw_state_e r_state;
  sw_state_e w_state_d;

  logic [CW-1:0] r_preset;
  logic [CW-1:0] r_snap;
  logic [CW-1:0] r_disp;
  logic          r_lap;
  logic          r_roll;

  logic [CW-1:0] w_count;
  logic [CW-1:0] w_count_d;
  logic [CW-1:0] w_snap_d;
  logic          w_lap_d;

  logic [NUM_FIELDS:0]   w_inc;
  logic [NUM_FIELDS-1:0] w_dec;
  logic [NUM_FIELDS-1:0] w_max;
  logic [NUM_FIELDS-1:0] w_zero;
  logic [NUM_FIELDS-1:0] w_adj;

  logic w_do_tick;
  logic w_do_dn;
  logic w_do_adj;
  logic w_all_zero;
  logic w_expire;
  logic w_load_preset;

  // A tick only counts when nothing of higher priority is pending.
  assign w_do_tick = (r_state == RUN) & tick_en & ~clr_pulse
                   & ~adj & ~pause_pulse;
  assign w_all_zero = &w_zero;
  assign w_do_dn    = w_do_tick & mode_down & ~w_all_zero;
  assign w_expire   = w_do_tick & mode_down
                    & (w_all_zero | (w_count_d == '0));
  assign w_do_adj   = (r_state == ADJUST) & adj & adj_tick & ~clr_pulse;
  assign w_load_preset = (r_state == ADJUST) & ~adj & ~clr_pulse;

  assign w_inc[0] = w_do_tick & ~mode_down;
  assign w_dec[0] = w_do_dn;

  for (genvar f = 0; f < NUM_FIELDS; f++) begin : g_field
    localparam int unsigned MOD = field_mod(f, NUM_FIELDS, TOP_LIMIT);

    assign w_adj[f]   = w_do_adj & (sel == SEL_W'(f));
    assign w_inc[f+1] = w_inc[f] & w_max[f];
    if (f > 0) begin : g_borrow
      assign w_dec[f] = w_dec[f-1] & w_zero[f-1];
    end

    bcd_field #(
      .MOD(MOD)
    ) u_field (
      .clk      (clk),
      .rst      (rst),
      .i_inc    (w_inc[f]),
      .i_dec    (w_dec[f]),
      .i_adj    (w_adj[f]),
      .i_set    (clr_pulse),
      .i_set_val(mode_down ? r_preset[8*f+:8] : 8'h00),
      .o_q      (w_count[8*f+:8]),
      .o_d      (w_count_d[8*f+:8]),
      .o_max    (w_max[f]),
      .o_zero   (w_zero[f])
    );
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      PAUSED:
        if (adj)              w_state_d = ADJUST;
        else if (pause_pulse) w_state_d = RUN;
      RUN:
        if (adj)              w_state_d = ADJUST;
        else if (pause_pulse) w_state_d = PAUSED;
        else if (w_expire)    w_state_d = EXPIRED;
      ADJUST:
        if (!adj)             w_state_d = PAUSED;
      EXPIRED:
        if (adj)              w_state_d = ADJUST;
        else if (!mode_down)  w_state_d = PAUSED;
      default:                w_state_d = PAUSED;
    endcase
    if (clr_pulse)
      w_state_d = (r_state == ADJUST && adj) ? ADJUST : PAUSED;
  end

  always_comb begin
    w_lap_d  = r_lap;
    w_snap_d = r_snap;
    if (clr_pulse) begin
      w_lap_d = 1'b0;
    end else if (lap_pulse) begin
      w_lap_d = ~r_lap;
      if (!r_lap)
        w_snap_d = w_count;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= PAUSED;
      r_preset <= '0;
      r_snap   <= '0;
      r_disp   <= '0;
      r_lap    <= 1'b0;
      r_roll   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_snap  <= w_snap_d;
      r_lap   <= w_lap_d;
      r_roll  <= w_inc[NUM_FIELDS];
      r_disp  <= w_lap_d ? w_snap_d : w_count_d;
      if (w_load_preset)
        r_preset <= w_count;
    end
  end

  assign count_bcd  = w_count;
  assign disp_bcd   = r_disp;
  assign running    = (r_state == RUN);
  assign expired    = (r_state == EXPIRED);
  assign lap_active = r_lap;
  assign rollover   = r_roll;

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core: default MM:SS instance
// plus a three-field 23:59:59 instance.
module tb_stopwatch_core;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        tick_en = 0, adj_tick = 0, pause_pulse = 0;
  logic        clr_pulse = 0, lap_pulse = 0, adj = 0, mode_down = 0;
  logic        sel = 0;
  logic [15:0] count_bcd, disp_bcd;
  logic        running, expired, lap_active, rollover;

  logic        t_tick_en = 0, t_adj_tick = 0, t_pause = 0;
  logic        t_clr = 0, t_lap = 0, t_adj = 0, t_mode_down = 0;
  logic [1:0]  t_sel = 0;
  logic [23:0] t_count, t_disp;
  logic        t_running, t_expired, t_lap_active, t_rollover;

  int n_chk = 0;
  int n_fail = 0;

  stopwatch_core dut (
    .clk(clk), .rst(rst), .tick_en(tick_en), .adj_tick(adj_tick),
    .pause_pulse(pause_pulse), .clr_pulse(clr_pulse),
    .lap_pulse(lap_pulse), .adj(adj), .sel(sel),
    .mode_down(mode_down), .count_bcd(count_bcd),
    .disp_bcd(disp_bcd), .running(running), .expired(expired),
    .lap_active(lap_active), .rollover(rollover)
  );

  stopwatch_core #(.NUM_FIELDS(3), .TOP_LIMIT(23)) dut3 (
    .clk(clk), .rst(rst), .tick_en(t_tick_en), .adj_tick(t_adj_tick),
    .pause_pulse(t_pause), .clr_pulse(t_clr),
    .lap_pulse(t_lap), .adj(t_adj), .sel(t_sel),
    .mode_down(t_mode_down), .count_bcd(t_count),
    .disp_bcd(t_disp), .running(t_running), .expired(t_expired),
    .lap_active(t_lap_active), .rollover(t_rollover)
  );

  function automatic logic [15:0] mmss(input int s);
    int m, ss;
    m = s / 60;
    ss = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tk(input int n);
    tick_en = 1;
    repeat (n) cyc();
    tick_en = 0;
  endtask

  task automatic pp();
    pause_pulse = 1; cyc(); pause_pulse = 0;
  endtask

  task automatic cp();
    clr_pulse = 1; cyc(); clr_pulse = 0;
  endtask

  task automatic lp();
    lap_pulse = 1; cyc(); lap_pulse = 0;
  endtask

  task automatic do_reset();
    tick_en = 0; adj_tick = 0; pause_pulse = 0; clr_pulse = 0;
    lap_pulse = 0; adj = 0; sel = 0; mode_down = 0;
    rst = 0;
    repeat (2) cyc();
    rst = 1;
    cyc();
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if ({count_bcd, disp_bcd} !== 32'h0 ||
        {running, expired, lap_active, rollover} !== 4'b0) begin
      $display("FAIL reset cnt=%h disp=%h flags=%b exp=0", count_bcd,
               disp_bcd, {running, expired, lap_active, rollover});
      n_fail++;
    end
  endtask

  task automatic test_count_up();
    do_reset();
    pp();
    n_chk++;
    if (running !== 1'b1) begin
      $display("FAIL up_run got=%b exp=1", running); n_fail++;
    end
    for (int i = 1; i <= 61; i++) begin
      tk(1);
      n_chk++;
      if (count_bcd !== mmss(i) || disp_bcd !== mmss(i)) begin
        $display("FAIL up_tick%0d cnt=%h disp=%h exp=%h", i, count_bcd,
                 disp_bcd, mmss(i));
        n_fail++;
      end
    end
    n_chk++;
    if (count_bcd !== 16'h0101 || running !== 1'b1) begin
      $display("FAIL up_final cnt=%h run=%b exp=0101/1", count_bcd,
               running);
      n_fail++;
    end
  endtask

  task automatic test_rollover();
    do_reset();
    pp();
    tk(3599);
    n_chk++;
    if (count_bcd !== 16'h5959 || rollover !== 1'b0) begin
      $display("FAIL roll_pre cnt=%h ro=%b exp=5959/0", count_bcd,
               rollover);
      n_fail++;
    end
    tk(1);
    n_chk++;
    if (count_bcd !== 16'h0000 || rollover !== 1'b1) begin
      $display("FAIL roll_wrap cnt=%h ro=%b exp=0000/1", count_bcd,
               rollover);
      n_fail++;
    end
    cyc();
    n_chk++;
    if (rollover !== 1'b0) begin
      $display("FAIL roll_pulse got=%b exp=0", rollover); n_fail++;
    end
  endtask

  task automatic test_count_down();
    do_reset();
    adj = 1; sel = 1;
    cyc();
    repeat (3) begin
      adj_tick = 1; cyc(); adj_tick = 0; cyc();
    end
    n_chk++;
    if (count_bcd !== 16'h0300) begin
      $display("FAIL dn_adj got=%h exp=0300", count_bcd); n_fail++;
    end
    adj = 0;
    cyc();
    mode_down = 1;
    pp();
    tk(179);
    n_chk++;
    if (count_bcd !== 16'h0001 || expired !== 1'b0) begin
      $display("FAIL dn_179 cnt=%h exp_flag=%b exp=0001/0", count_bcd,
               expired);
      n_fail++;
    end
    tk(1);
    n_chk++;
    if (count_bcd !== 16'h0000 || expired !== 1'b1 ||
        running !== 1'b0) begin
      $display("FAIL dn_zero cnt=%h ex=%b run=%b exp=0000/1/0",
               count_bcd, expired, running);
      n_fail++;
    end
    tk(3);
    n_chk++;
    if (count_bcd !== 16'h0000 || expired !== 1'b1) begin
      $display("FAIL dn_hold cnt=%h ex=%b exp=0000/1", count_bcd,
               expired);
      n_fail++;
    end
    cp();
    n_chk++;
    if (count_bcd !== 16'h0300 || expired !== 1'b0 ||
        running !== 1'b0) begin
      $display("FAIL dn_reload cnt=%h ex=%b run=%b exp=0300/0/0",
               count_bcd, expired, running);
      n_fail++;
    end
    mode_down = 0;
    cp();
    mode_down = 1;
    pp();
    tk(1);
    n_chk++;
    if (count_bcd !== 16'h0000 || expired !== 1'b1) begin
      $display("FAIL dn_tick_at_zero cnt=%h ex=%b exp=0000/1",
               count_bcd, expired);
      n_fail++;
    end
    mode_down = 0;
    cyc();
    n_chk++;
    if (expired !== 1'b0 || running !== 1'b0) begin
      $display("FAIL dn_mode_exit ex=%b run=%b exp=0/0", expired,
               running);
      n_fail++;
    end
  endtask

  task automatic test_lap();
    do_reset();
    pp();
    tk(10);
    lp();
    n_chk++;
    if (lap_active !== 1'b1 || disp_bcd !== 16'h0010) begin
      $display("FAIL lap_on lap=%b disp=%h exp=1/0010", lap_active,
               disp_bcd);
      n_fail++;
    end
    tk(5);
    n_chk++;
    if (disp_bcd !== 16'h0010 || count_bcd !== 16'h0015) begin
      $display("FAIL lap_hold disp=%h cnt=%h exp=0010/0015", disp_bcd,
               count_bcd);
      n_fail++;
    end
    lp();
    n_chk++;
    if (disp_bcd !== 16'h0015 || lap_active !== 1'b0) begin
      $display("FAIL lap_off disp=%h lap=%b exp=0015/0", disp_bcd,
               lap_active);
      n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    pp();
    tk(42);
    n_chk++;
    if (count_bcd !== 16'h0042) begin
      $display("FAIL b2b_pre got=%h exp=0042", count_bcd); n_fail++;
    end
    clr_pulse = 1; pause_pulse = 1; tick_en = 1; lap_pulse = 1;
    cyc();
    clr_pulse = 0; pause_pulse = 0; tick_en = 0; lap_pulse = 0;
    n_chk++;
    if (count_bcd !== 16'h0000 || disp_bcd !== 16'h0000 ||
        running !== 1'b0 || lap_active !== 1'b0) begin
      $display("FAIL b2b_clr cnt=%h disp=%h run=%b lap=%b exp=0/0/0/0",
               count_bcd, disp_bcd, running, lap_active);
      n_fail++;
    end
    pp();
    tk(3);
    lp();
    n_chk++;
    if (count_bcd !== 16'h0003 || lap_active !== 1'b1 ||
        running !== 1'b1) begin
      $display("FAIL b2b_run cnt=%h lap=%b run=%b exp=0003/1/1",
               count_bcd, lap_active, running);
      n_fail++;
    end
    #2 rst = 0;
    #1;
    n_chk++;
    if ({count_bcd, disp_bcd} !== 32'h0 ||
        {running, expired, lap_active, rollover} !== 4'b0) begin
      $display("FAIL async_rst cnt=%h disp=%h flags=%b exp=0",
               count_bcd, disp_bcd,
               {running, expired, lap_active, rollover});
      n_fail++;
    end
    cyc();
    rst = 1;
    cyc();
  endtask

  task automatic t_adjust(input logic [1:0] s, input int n);
    t_sel = s;
    t_adj_tick = 1;
    repeat (n) cyc();
    t_adj_tick = 0;
  endtask

  task automatic test_three_fields();
    do_reset();
    t_adj = 1;
    cyc();
    t_adjust(2'd2, 23);
    t_adjust(2'd1, 59);
    t_adjust(2'd0, 59);
    n_chk++;
    if (t_count !== 24'h235959) begin
      $display("FAIL f3_set got=%h exp=235959", t_count); n_fail++;
    end
    t_adj = 0;
    cyc();
    t_pause = 1; cyc(); t_pause = 0;
    t_tick_en = 1; cyc(); t_tick_en = 0;
    n_chk++;
    if (t_count !== 24'h000000 || t_rollover !== 1'b1 ||
        t_disp !== 24'h000000) begin
      $display("FAIL f3_wrap cnt=%h ro=%b disp=%h exp=000000/1/000000",
               t_count, t_rollover, t_disp);
      n_fail++;
    end
    t_adj = 1;
    cyc();
    t_adjust(2'd2, 23);
    n_chk++;
    if (t_count !== 24'h230000) begin
      $display("FAIL f3_adj23 got=%h exp=230000", t_count); n_fail++;
    end
    t_adjust(2'd2, 1);
    n_chk++;
    if (t_count !== 24'h000000 || t_rollover !== 1'b0) begin
      $display("FAIL f3_adjwrap cnt=%h ro=%b exp=000000/0", t_count,
               t_rollover);
      n_fail++;
    end
    t_adjust(2'd1, 7);
    t_adjust(2'd0, 60);
    n_chk++;
    if (t_count !== 24'h000700) begin
      $display("FAIL f3_nocarry got=%h exp=000700", t_count); n_fail++;
    end
    t_adjust(2'd3, 4);
    n_chk++;
    if (t_count !== 24'h000700) begin
      $display("FAIL f3_sel3 got=%h exp=000700", t_count); n_fail++;
    end
    t_adj = 0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_rollover();
    test_count_down();
    test_lap();
    test_back_to_back();
    test_three_fields();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_core.md
Name: stopwatch_core

Overview:
Parametrised successor to the fixed MM:SS counter. It is a multi-field BCD time core with the following behaviour:
- NUM_FIELDS two-digit fields.
- Count-up or count-down mode.
- Per-field adjust.
- Lap (split) hold.
- Preset reload with expiry detection.

It sits between the clock divider/debouncers and the seven-segment/display path. It consumes 1 Hz and 2 Hz strobes plus single-cycle button pulses, and drives packed BCD digits to the decoders.

Parameters:
NUM_FIELDS, 2, number of two-digit BCD fields; field 0 = seconds, field 1 = minutes, field 2 = hours, and so on (must be >= 1).
TOP_LIMIT, 59, maximum value of the most-significant field (all lower fields are fixed at modulo 60; TOP_LIMIT <= 99).
SEL_W, (NUM_FIELDS>1 ? $clog2(NUM_FIELDS) : 1), width of the field select.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
tick_en  in  1  one-cycle count strobe (1 Hz)
adj_tick  in  1  one-cycle adjust strobe (2 Hz)
pause_pulse  in  1  debounced one-cycle pulse; toggles run/pause
clr_pulse  in  1  debounced one-cycle pulse; clear/reload
lap_pulse  in  1  debounced one-cycle pulse; toggles lap hold
adj  in  1  level; adjust mode while high
sel  in  SEL_W  field selected for adjust
mode_down  in  1  level; 1 = count down, 0 = count up
count_bcd  out  8*NUM_FIELDS  live count; field f occupies bits [8f+7:8f], tens digit in the upper nibble
disp_bcd  out  8*NUM_FIELDS  display value (live count, or the lap snapshot while lap_active)
running  out  1  state == RUN
expired  out  1  state == EXPIRED
lap_active  out  1  lap hold engaged
rollover  out  1  one-cycle pulse on count-up wrap from maximum to zero

Behaviour:
- Reset (rst low, asynchronous): count = 0, preset = 0, lap snapshot = 0, state = PAUSED. All outputs are 0.
- All outputs are registered. A count change appears on count_bcd the cycle after the qualifying strobe. disp_bcd follows count_bcd with the same latency when not in lap hold.
- States: PAUSED, RUN, ADJUST, EXPIRED.
  - PAUSED: pause_pulse -> RUN. adj=1 -> ADJUST.
  - RUN: tick_en steps the count. pause_pulse -> PAUSED. adj=1 -> ADJUST.
  - ADJUST: counting is suspended. On adj_tick, field sel increments by 1 modulo its limit (60, or TOP_LIMIT+1 for the top field), with no carry into other fields.
    - sel >= NUM_FIELDS: no effect.
    - adj=0 -> PAUSED, and the count is copied into preset in the same cycle.
    - pause_pulse is ignored.
  - EXPIRED: the count holds at zero. pause_pulse is ignored. clr_pulse -> reload preset, PAUSED. adj=1 -> ADJUST (expired clears).
- Count-up: field 0 increments. Each field wraps at its limit and carries into the next field. If every field is at its maximum, the count wraps to all-zero and rollover pulses for one cycle.
- Count-down: field 0 decrements, with borrow from higher fields; each field wraps to its maximum on borrow.
  - A tick that produces all-zero -> EXPIRED in the same update.
  - A tick arriving with the count already zero -> EXPIRED, with no decrement.
- clr_pulse:
  - Count-up mode: count = 0.
  - Count-down mode: count = preset.
  - State becomes PAUSED unless in ADJUST; in ADJUST the count still clears/reloads and the state stays ADJUST.
- Lap hold:
  - lap_pulse with lap_active=0 captures count into the snapshot and sets lap_active.
  - lap_pulse with lap_active=1 clears lap_active.
  - Counting continues underneath the hold. clr_pulse also releases the hold.
- Priority within one cycle: reset > clr_pulse > adj entry/exit > pause_pulse > tick_en/adj_tick. lap_pulse is independent; on a same-cycle clr_pulse and lap_pulse, clr wins and lap_active ends at 0.
- mode_down changes take effect on the next tick. A change of mode_down while in EXPIRED with mode_down=0 -> PAUSED.

Decomposition:
- Package stopwatch_pkg: the state enum (PAUSED, RUN, ADJUST, EXPIRED), the FIELD_MOD=60 constant, and a function computing field width.
- Sub-module bcd_field: a two-digit BCD modulo-N up/down counter with inc/dec/set inputs and carry/borrow outputs.
- stopwatch_core generates NUM_FIELDS instances of bcd_field, chaining carry/borrow between them, with the top-field limit set by TOP_LIMIT.

Test Plan:
1. Default params, reset, pause_pulse, 61 tick_en strobes -> count_bcd = 16'h0101, running = 1; disp_bcd equals count_bcd one cycle after each tick.
2. Count 59:59, then one tick -> count_bcd = 16'h0000 and a single-cycle rollover pulse.
3. adj=1, sel=1, 3 adj_ticks, adj=0, mode_down=1, pause_pulse, 180 ticks -> count reaches 0, expired = 1, further ticks ignored; clr_pulse -> count_bcd = 16'h0300, state PAUSED.
4. Running at 00:10, lap_pulse, 5 ticks -> disp_bcd = 16'h0010 and count_bcd = 16'h0015; lap_pulse again -> disp_bcd = 16'h0015.
5. Same-cycle clr_pulse, pause_pulse, tick_en and lap_pulse at 00:42 -> count = 0, PAUSED, lap_active = 0; rst asserted mid-RUN -> all outputs 0 immediately, with no clk edge required.
6. NUM_FIELDS=3, TOP_LIMIT=23: count 23:59:59 up one tick -> all-zero with rollover; adj on sel=2 at 23 -> 00 with no carry.
